rf_bank_req_queue: RTL and testbench

Per-bank register-file request queue for the operand-collector path. Accepts up to two source-operand read requests per cycle from the register allocation unit. Issues one register-file access per cycle with registered outputs. CDB writebacks take priority and stall reads. Generalised in depth and field widths, and adds back-pressure, flush, occupancy and error reporting.

---
 rtl/rf_bank_req_queue.sv | 138 +++++++++++++
 tb/tb_rf_bank_req_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_bank_req_queue.sv
// rf_bank_req_queue
//   Per-bank register-file request queue for the operand-collector path.
//   Accepts up to two source-operand read requests per cycle. It issues
//   one registered register-file access per cycle. A CDB writeback takes
//   priority over a queued read and stalls reads for that cycle.
//
// Ports
//   clk, rst (async, active-low), flush (sync clear of the queue)
//   src1_* / src2_*  : read requests {valid, row, ocid}
//   push_ready       : two free slots are available (depends on state only)
//   wr_valid/row/data: CDB writeback request
//   rf_rd_valid, rf_we, rf_addr, rf_ocid, rf_wdata : registered RF access
//   count            : occupancy
//   overflow_err     : sticky; a request arrived while push_ready was 0
module rf_bank_req_queue #(
  parameter int DEPTH  = 8,
  parameter int ROW_W  = 3,
  parameter int OCID_W = 3,
  parameter int DATA_W = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     src1_valid,
  input  logic [ROW_W-1:0]         src1_row,
  input  logic [OCID_W-1:0]        src1_ocid,
  input  logic                     src2_valid,
  input  logic [ROW_W-1:0]         src2_row,
  input  logic [OCID_W-1:0]        src2_ocid,
  output logic                     push_ready,
  input  logic                     wr_valid,
  input  logic [ROW_W-1:0]         wr_row,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     rf_rd_valid,
  output logic                     rf_we,
  output logic [ROW_W-1:0]         rf_addr,
  output logic [OCID_W-1:0]        rf_ocid,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ROW_W-1:0]  mem_row  [DEPTH];
  logic [OCID_W-1:0] mem_ocid [DEPTH];

  logic [PW-1:0] rp;
  logic [PW-1:0] wp;
  logic [PW-1:0] free_slots;
  logic [PW-1:0] push_cnt;
  logic [AW-1:0] wr_idx0;
  logic [AW-1:0] wr_idx1;
  logic [AW-1:0] rd_idx;
  logic          push_req;
  logic          push;
  logic          pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count      = wp - rp;
  assign free_slots = PW'(DEPTH) - count;
  // Readiness always reserves room for a pair, even for a single request.
  assign push_ready = (free_slots >= PW'(2));

  assign push_req = src1_valid | src2_valid;
  assign push     = push_req & push_ready & ~flush;
  assign pop      = (count != '0) & ~wr_valid & ~flush;
  assign push_cnt = (src1_valid & src2_valid) ? PW'(2) : PW'(1);

  assign wr_idx0 = wp[AW-1:0];
  assign wr_idx1 = wr_idx0 + AW'(1);
  assign rd_idx  = rp[AW-1:0];

  // Storage needs no reset; only entries between rp and wp are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      if (src1_valid) begin
        mem_row[wr_idx0]  <= src1_row;
        mem_ocid[wr_idx0] <= src1_ocid;
        if (src2_valid) begin
          mem_row[wr_idx1]  <= src2_row;
          mem_ocid[wr_idx1] <= src2_ocid;
        end
      end else begin
        mem_row[wr_idx0]  <= src2_row;
        mem_ocid[wr_idx0] <= src2_ocid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp <= '0;
      wp <= '0;
    end else if (flush) begin
      rp <= '0;
      wp <= '0;
    end else begin
      if (pop) rp <= rp + PW'(1);
      if (push) wp <= wp + push_cnt;
    end
  end

  // A dropped request is flagged even when a flush in the same cycle
  // would have discarded it anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_err <= 1'b0;
    end else if (push_req && !push_ready) begin
      overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_rd_valid <= 1'b0;
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_ocid     <= '0;
      rf_wdata    <= '0;
    end else if (wr_valid) begin
      rf_rd_valid <= 1'b0;
      rf_we       <= 1'b1;
      rf_addr     <= wr_row;
      rf_wdata    <= wr_data;
    end else if (pop) begin
      rf_rd_valid <= 1'b1;
      rf_we       <= 1'b0;
      rf_addr     <= mem_row[rd_idx];
      rf_ocid     <= mem_ocid[rd_idx];
    end else begin
      rf_rd_valid <= 1'b0;
      rf_we       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_bank_req_queue.sv
module tb_rf_bank_req_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 256;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              src1_valid;
  logic [2:0]        src1_row;
  logic [2:0]        src1_ocid;
  logic              src2_valid;
  logic [2:0]        src2_row;
  logic [2:0]        src2_ocid;
  logic              push_ready;
  logic              wr_valid;
  logic [2:0]        wr_row;
  logic [DATA_W-1:0] wr_data;
  logic              rf_rd_valid;
  logic              rf_we;
  logic [2:0]        rf_addr;
  logic [2:0]        rf_ocid;
  logic [DATA_W-1:0] rf_wdata;
  logic [3:0]        count;
  logic              overflow_err;

  rf_bank_req_queue #(.DEPTH(DEPTH), .ROW_W(3), .OCID_W(3), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src1_valid(src1_valid), .src1_row(src1_row), .src1_ocid(src1_ocid),
    .src2_valid(src2_valid), .src2_row(src2_row), .src2_ocid(src2_ocid),
    .push_ready(push_ready),
    .wr_valid(wr_valid), .wr_row(wr_row), .wr_data(wr_data),
    .rf_rd_valid(rf_rd_valid), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_ocid(rf_ocid), .rf_wdata(rf_wdata),
    .count(count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: an unbounded queue of requests plus the output values
  // it should be presenting.
  typedef struct packed {
    logic [2:0] ocid;
    logic [2:0] row;
  } ent_t;
  ent_t              mq[$];
  logic              m_rd, m_we, m_ovf;
  logic [2:0]        m_addr, m_ocid;
  logic [DATA_W-1:0] m_wdata;

  function automatic void chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_rd = 0; m_we = 0; m_ovf = 0;
    m_addr = 0; m_ocid = 0; m_wdata = '0;
  endfunction

  function automatic void model_edge();
    bit   any_req, rdy, do_pop;
    ent_t h, e;
    any_req = src1_valid || src2_valid;
    rdy     = (DEPTH - mq.size()) >= 2;
    do_pop  = (mq.size() != 0) && !wr_valid && !flush;
    if (any_req && !rdy) m_ovf = 1;
    if (do_pop) h = mq.pop_front();
    if (wr_valid) begin
      m_we = 1; m_rd = 0; m_addr = wr_row; m_wdata = wr_data;
    end else if (do_pop) begin
      m_rd = 1; m_we = 0; m_addr = h.row; m_ocid = h.ocid;
    end else begin
      m_rd = 0; m_we = 0;
    end
    if (flush) begin
      mq.delete();
    end else if (any_req && rdy) begin
      if (src1_valid) begin e.row = src1_row; e.ocid = src1_ocid; mq.push_back(e); end
      if (src2_valid) begin e.row = src2_row; e.ocid = src2_ocid; mq.push_back(e); end
    end
  endfunction

  function automatic void check_all();
    chk("rd_valid", rf_rd_valid, m_rd);
    chk("we", rf_we, m_we);
    chk("addr", rf_addr, m_addr);
    chk("ocid", rf_ocid, m_ocid);
    chk("wdata", rf_wdata, m_wdata);
    chk("count", count, mq.size());
    chk("push_ready", push_ready, (DEPTH - mq.size()) >= 2);
    chk("overflow_err", overflow_err, m_ovf);
  endfunction

  task automatic drive(bit s1v, logic [2:0] s1r, logic [2:0] s1o,
                       bit s2v, logic [2:0] s2r, logic [2:0] s2o,
                       bit wrv, logic [2:0] wrr, logic [DATA_W-1:0] wd, bit fl);
    src1_valid = s1v; src1_row = s1r; src1_ocid = s1o;
    src2_valid = s2v; src2_row = s2r; src2_ocid = s2o;
    wr_valid = wrv; wr_row = wrr; wr_data = wd; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
  endtask

  // Inputs change on the falling edge, the model follows the rising edge,
  // and the outputs are compared on the next falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit         s1v; logic [2:0] s1r; logic [2:0] s1o;
    bit         s2v; logic [2:0] s2r; logic [2:0] s2o;
    bit         wrv; logic [2:0] wrr; logic [7:0] wd8;
    bit         e_rd; bit e_we; logic [2:0] e_addr; logic [2:0] e_ocid;
    logic [3:0] e_cnt; logic [7:0] e_wd8;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // order after reset, then write priority with 3 entries queued
    tbl[0]  = '{1, 2, 1, 1, 5, 3, 0, 0, 8'h00, 0, 0, 0, 0, 2, 8'h00};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 2, 1, 1, 8'h00};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 5, 3, 0, 8'h00};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 5, 3, 0, 8'h00};
    tbl[4]  = '{1, 1, 4, 1, 3, 5, 0, 0, 8'h00, 0, 0, 5, 3, 2, 8'h00};
    tbl[5]  = '{1, 7, 6, 0, 0, 0, 1, 6, 8'hA5, 0, 1, 6, 3, 3, 8'hA5};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 6, 8'hA5, 0, 1, 6, 3, 3, 8'hA5};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 4, 2, 8'hA5};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 3, 5, 1, 8'hA5};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 7, 6, 0, 8'hA5};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 7, 6, 0, 8'hA5};

    rst = 1'b0;
    idle();
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].s1v, tbl[i].s1r, tbl[i].s1o, tbl[i].s2v, tbl[i].s2r, tbl[i].s2o,
            tbl[i].wrv, tbl[i].wrr, {32{tbl[i].wd8}}, 0);
      step();
      chk($sformatf("tbl%0d_rd", i), rf_rd_valid, tbl[i].e_rd);
      chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_addr", i), rf_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_ocid", i), rf_ocid, tbl[i].e_ocid);
      chk($sformatf("tbl%0d_cnt", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_wdata", i), rf_wdata, {32{tbl[i].e_wd8}});
    end

    // fill with writebacks blocking pops, then overflow
    for (int k = 0; k < 4; k++) begin
      drive(1, 3'(2 * k), 3'(k), 1, 3'(2 * k + 1), 3'(7 - k), 1, 3'(k), {8{32'(k + 100)}}, 0);
      step();
    end
    chk("fill_count", count, 8);
    chk("fill_ready", push_ready, 0);
    chk("fill_no_ovf", overflow_err, 0);
    drive(1, 6, 6, 1, 7, 7, 1, 2, '1, 0);
    step();
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", count, 8);
    idle();
    for (int k = 0; k < 9; k++) step();
    chk("drain_empty", count, 0);

    // boundary: one slot free still refuses a single push, even with a pop
    for (int k = 0; k < 3; k++) begin
      drive(1, 3'(k), 3'(k + 1), 1, 3'(k + 4), 3'(k + 2), 1, 5, '0, 0);
      step();
    end
    drive(1, 3, 3, 0, 0, 0, 1, 5, '0, 0);
    step();
    chk("cnt7", count, 7);
    chk("cnt7_ready", push_ready, 0);
    drive(0, 0, 0, 1, 2, 2, 0, 0, '0, 0);
    step();
    chk("cnt7_pop_drop", count, 6);
    idle();
    for (int k = 0; k < 7; k++) step();

    // flush with 5 entries and a simultaneous writeback
    drive(1, 1, 1, 1, 2, 2, 1, 4, '0, 0); step();
    drive(1, 3, 3, 1, 4, 4, 1, 4, '0, 0); step();
    drive(1, 5, 5, 0, 0, 0, 1, 4, '0, 0); step();
    chk("pre_flush_cnt", count, 5);
    drive(1, 6, 6, 1, 7, 7, 1, 1, {32{8'h3C}}, 1);
    step();
    chk("flush_we", rf_we, 1);
    chk("flush_addr", rf_addr, 1);
    chk("flush_rd", rf_rd_valid, 0);
    chk("flush_cnt", count, 0);
    chk("flush_ovf_kept", overflow_err, 1);
    idle();
    step();

    // random pushes with continuous pops, then fully mixed traffic
    for (int k = 0; k < 80; k++) begin
      drive($urandom_range(0, 1), 3'($urandom), 3'($urandom),
            $urandom_range(0, 1), 3'($urandom), 3'($urandom),
            (k >= 20) && ($urandom_range(0, 3) == 0), 3'($urandom),
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            (k >= 20) && ($urandom_range(0, 19) == 0));
      step();
      chk("count_le_depth", count <= DEPTH, 1);
    end
    idle();
    for (int k = 0; k < 9; k++) step();

    // async reset while reads are issuing
    drive(1, 2, 3, 1, 4, 5, 0, 0, '0, 0); step();
    drive(1, 6, 7, 0, 0, 0, 0, 0, '0, 0); step();
    chk("pre_rst_rd", rf_rd_valid, 1);
    idle();
    @(posedge clk);
    model_edge();
    #2 rst = 1'b0;
    #1;
    chk("arst_rd", rf_rd_valid, 0);
    chk("arst_we", rf_we, 0);
    chk("arst_addr", rf_addr, 0);
    chk("arst_ocid", rf_ocid, 0);
    chk("arst_count", count, 0);
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    check_all();
    chk("post_rst_ready", push_ready, 1);
    drive(0, 0, 0, 1, 3, 2, 0, 0, '0, 0); step();
    idle();
    step();
    chk("post_rst_read", rf_addr, 3);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
